key_schedule_seq: RTL and testbench
===================================

// Module: key_schedule_seq
// PURPOSE
//  Iterative AES-128 key expansion. Feeds the round-key inputs (key, round1_key..round10_key) of the pipelined encrypt datapath.
//  - Captures a 128-bit cipher key on a start pulse.
//  - Produces one round key per clock.
//  - Holds all 11 keys in registers and flags keys_valid once round 10 is written.
// PARAMETERS
//  NR        10   number of rounds; fixed for AES-128, the only supported value
//  KEY_W     128  key / round-key width in bits
// PORTS
//  clk          in   1    single clock; all state updates on posedge
//  rst_n        in   1    asynchronous, active-low reset
//  start        in   1    1-cycle request; sampled on posedge clk
//  key_in       in   128  cipher key; byte 0 = key_in[127:120]; sampled only when start is accepted
//  busy         out  1    high while expansion is in progress
//  keys_valid   out  1    high while key_out..round10_key hold a complete, consistent schedule
//  key_out      out  128  round-0 key (copy of captured key_in)
//  round1_key..round10_key  out  128 each  expanded round keys 1..10
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, busy=0, keys_valid=0, rcon=8'h01, round counter=0, all key outputs=128'h0.
//  - FSM states:
//    - IDLE: waiting, no schedule held.
//    - EXPAND: computing rounds 1..10.
//    - DONE: schedule held.
//  - FSM transitions:
//    - IDLE/DONE + start -> EXPAND. At that edge: key_out<=key_in, rnd<=1, rcon<=01, busy<=1, keys_valid<=0.
//    - EXPAND: each edge writes round<rnd>_key = f(previous key, rcon), then rnd++ and rcon=xtime(rcon).
//      - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
//    - EXPAND with rnd==10: writes round10_key; -> DONE, busy<=0, keys_valid<=1 at the same edge.
//  - Latency: start accepted at edge T0.
//    - round_k written at edge T0+k.
//    - keys_valid=1 and busy=0 visible after T0+10.
//    - 10 cycles start-to-valid.
//  - Round function, with prev = {w0,w1,w2,w3}, w0 = prev[127:96]:
//    - t  = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
//    - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
//    - All XORs are bitwise; no carries.
//  - Boundary conditions:
//    - start while EXPAND: ignored. The current expansion completes with the originally captured key; key_in is not resampled.
//    - start in DONE: restart. keys_valid drops at the accept edge. Round keys from the old schedule are overwritten one per cycle; consumers must gate on keys_valid.
//    - start held high for multiple cycles: first cycle accepted, later cycles ignored while busy. If still high in DONE, a new expansion starts.
//    - rst_n asserted mid-EXPAND: immediate return to IDLE with all outputs cleared. No partial schedule is ever flagged valid.
//    - keys_valid and busy are never both 1.
//  - Round keys are stable (no combinational path to inputs) whenever keys_valid=1.
// STRUCTURE
//  - Shared package aes_pkg:
//    - KEY_W, NR.
//    - function xtime(byte).
//    - rcon table / initial value 8'h01.
//    - FSM state encoding (IDLE=2'd0, EXPAND=2'd1, DONE=2'd2).
//    - Used by the encrypt/decrypt blocks as well.
//  - Sub-module aes_sbox:
//    - 8-bit combinational forward S-box.
//    - 4 instances implement SubWord.
//    - The same module serves the SubBytes stage.
//  - Top level holds:
//    - the FSM;
//    - a 4-bit round counter;
//    - an 8-bit rcon register;
//    - 11x128-bit key registers;
//    - a single shared round-function datapath whose input is muxed from the previous round's register.
// TESTING
//  1. FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle.
//     -> round1_key=a0fafe1788542cb123a339392a6c7605, round10_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
//     -> keys_valid rises exactly 10 cycles after the accept edge.
//  2. All-zero key.
//     -> round1_key=62636363626363636263636362636363, round10_key=b4ef5bcb3e92e21123e951cf6f8f188e.
//  3. start pulsed again at cycle T0+4 with a different key_in.
//     -> ignored; results identical to scenario 1; busy stays 1 until T0+10.
//  4. Assert rst_n=0 at T0+5.
//     -> busy=0, keys_valid=0, all keys=0 immediately (async); no valid afterwards without a new start.
//  5. After DONE (scenario 1), start with the zero key.
//     -> keys_valid falls at the accept edge; after 10 cycles scenario-2 values are held.
//  6. Chain into the encrypt pipeline with plaintext 3243f6a8885a308d313198a2e0370734 (A.1 key).
//     -> cypher_text=3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round count, GF(2^8) helpers and the
// key-schedule FSM encoding. The encrypt/decrypt blocks import this package too.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int NR    = 10;

  // First round constant; each later rcon is xtime() of the one before:
  // 01,02,04,08,10,20,40,80,1b,36.
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational; also used by the SubBytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_inv;
  logic [7:0] w_pow;

  // Inverse as x^254 = product of x^(2^i) for i = 1..7 (zero maps to zero).
  always_comb begin
    w_pow = gf_mul(i_byte, i_byte);
    w_inv = w_pow;
    for (int i = 2; i < 8; i++) begin
      w_pow = gf_mul(w_pow, w_pow);
      w_inv = gf_mul(w_inv, w_pow);
    end
  end

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Iterative AES-128 key expansion: one round key per clock, all 11 keys held
// in registers. keys_valid is raised only on the edge that writes round 10.
//
// Handshake: start is a single-cycle request sampled on posedge clk. It is
// accepted whenever the block is not busy (IDLE or DONE); while busy it is
// ignored and key_in is not resampled. busy and keys_valid are never both 1.
module key_schedule_seq
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             keys_valid,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W-1:0] round1_key,
  output logic [KEY_W-1:0] round2_key,
  output logic [KEY_W-1:0] round3_key,
  output logic [KEY_W-1:0] round4_key,
  output logic [KEY_W-1:0] round5_key,
  output logic [KEY_W-1:0] round6_key,
  output logic [KEY_W-1:0] round7_key,
  output logic [KEY_W-1:0] round8_key,
  output logic [KEY_W-1:0] round9_key,
  output logic [KEY_W-1:0] round10_key,
  output logic [1:0]       dbg_state
);

  ks_state_t        r_state;
  ks_state_t        w_state_nxt;
  logic [3:0]       r_rnd;
  logic [7:0]       r_rcon;
  logic             r_busy;
  logic             r_valid;
  logic [KEY_W-1:0] r_keys [0:NR];

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [KEY_W-1:0] w_prev;
  logic [KEY_W-1:0] w_next;
  logic [31:0]      w_rot;
  logic [31:0]      w_sub;
  logic [31:0]      w_t;
  logic [31:0]      w_n0;
  logic [31:0]      w_n1;
  logic [31:0]      w_n2;
  logic [31:0]      w_n3;

  assign w_last = (r_rnd == 4'(NR));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the accept/step strobes that drive the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round counter, rcon and the busy/valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd   <= 4'd0;
      r_rcon  <= RCON_INIT;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_rnd   <= 4'd1;
      r_rcon  <= RCON_INIT;
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
    end else if (w_step) begin
      r_rnd  <= r_rnd + 4'd1;
      r_rcon <= xtime(r_rcon);
      if (w_last) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end
    end
  end

  // Select the previous round's key as the shared round-function input.
  always_comb begin
    w_prev = '0;
    for (int i = 1; i <= NR; i++) begin
      if (r_rnd == 4'(i)) w_prev = r_keys[i-1];
    end
  end

  // RotWord of w3, then SubWord through four S-boxes.
  assign w_rot = {w_prev[23:0], w_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  // Word chaining of the round function.
  always_comb begin
    w_t    = w_sub ^ {r_rcon, 24'h0};
    w_n0   = w_prev[127:96] ^ w_t;
    w_n1   = w_prev[95:64]  ^ w_n0;
    w_n2   = w_prev[63:32]  ^ w_n1;
    w_n3   = w_prev[31:0]   ^ w_n2;
    w_next = {w_n0, w_n1, w_n2, w_n3};
  end

  // Key storage: round 0 captured on accept, round r_rnd written each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) r_keys[i] <= '0;
    end else if (w_accept) begin
      r_keys[0] <= key_in;
    end else if (w_step) begin
      for (int i = 1; i <= NR; i++) begin
        if (r_rnd == 4'(i)) r_keys[i] <= w_next;
      end
    end
  end

  assign busy        = r_busy;
  assign keys_valid  = r_valid;
  assign key_out     = r_keys[0];
  assign round1_key  = r_keys[1];
  assign round2_key  = r_keys[2];
  assign round3_key  = r_keys[3];
  assign round4_key  = r_keys[4];
  assign round5_key  = r_keys[5];
  assign round6_key  = r_keys[6];
  assign round7_key  = r_keys[7];
  assign round8_key  = r_keys[8];
  assign round9_key  = r_keys[9];
  assign round10_key = r_keys[10];
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: directed scenarios with a scoreboard of
// expected {key_out, round1_key, round10_key} checked when keys_valid rises.
module tb_key_schedule_seq;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z   = 128'h0;
  localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic [1:0]   dbg_state;
  logic [127:0] rk [0:10];

  logic [127:0] exp_q[$];
  int           n_cmp;
  int           n_err;

  key_schedule_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
    .busy        (busy),
    .keys_valid  (keys_valid),
    .key_out     (rk[0]),
    .round1_key  (rk[1]),
    .round2_key  (rk[2]),
    .round3_key  (rk[3]),
    .round4_key  (rk[4]),
    .round5_key  (rk[5]),
    .round6_key  (rk[6]),
    .round7_key  (rk[7]),
    .round8_key  (rk[8]),
    .round9_key  (rk[9]),
    .round10_key (rk[10]),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sched(input logic [127:0] k, input logic [127:0] r1, input logic [127:0] r10);
    exp_q.push_back(k);
    exp_q.push_back(r1);
    exp_q.push_back(r10);
  endtask

  // Pop one expected schedule and compare it with the held outputs.
  task automatic check_sched(input string tag);
    if (exp_q.size() < 3) begin
      chk({tag, "_sb_depth"}, 128'(exp_q.size()), 128'd3);
    end else begin
      chk({tag, "_key_out"}, rk[0],  exp_q.pop_front());
      chk({tag, "_round1"},  rk[1],  exp_q.pop_front());
      chk({tag, "_round10"}, rk[10], exp_q.pop_front());
    end
  endtask

  // Drive a one-cycle start; returns just after the accept edge T0.
  task automatic do_start(input string tag, input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk({tag, "_accept_flags"}, 128'({busy, keys_valid}), 128'(2'b10));
    chk({tag, "_accept_state"}, 128'(dbg_state), 128'(2'd1));
    chk({tag, "_accept_key0"},  rk[0], k);
  endtask

  // Run edges T0+1..T0+10 checking busy/valid each cycle; optionally
  // pulse start (with another key) so that it is sampled at edge T0+pulse_at+1.
  task automatic run_expand(input string tag, input logic [127:0] exp_r1,
                            input int pulse_at, input logic [127:0] pulse_key);
    for (int k = 1; k <= 10; k++) begin
      if (pulse_at > 0 && k == pulse_at + 1) begin
        key_in = pulse_key;
        start  = 1'b1;
      end
      step();
      start = 1'b0;
      if (k == 1) chk({tag, "_round1_t1"}, rk[1], exp_r1);
      if (k < 10) chk($sformatf("%s_flags_t%0d", tag, k), 128'({busy, keys_valid}), 128'(2'b10));
      else        chk({tag, "_flags_t10"}, 128'({busy, keys_valid}), 128'(2'b01));
    end
    chk({tag, "_done_state"}, 128'(dbg_state), 128'(2'd2));
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;

    // Reset state
    step();
    step();
    chk("rst_flags",   128'({busy, keys_valid}), 128'(2'b00));
    chk("rst_state",   128'(dbg_state), 128'(2'd0));
    chk("rst_key_out", rk[0], 128'h0);
    chk("rst_round10", rk[10], 128'h0);
    rst_n = 1'b1;
    step();
    chk("idle_state", 128'(dbg_state), 128'(2'd0));

    // FIPS-197 A.1 key
    push_sched(KEY_A1, A1_R1, A1_R10);
    do_start("a1", KEY_A1);
    run_expand("a1", A1_R1, 0, '0);
    check_sched("a1");
    step();
    chk("a1_hold_r10", rk[10], A1_R10);

    // Restart from DONE with the all-zero key
    push_sched(KEY_Z, Z_R1, Z_R10);
    do_start("zero", KEY_Z);
    run_expand("zero", Z_R1, 0, '0);
    check_sched("zero");

    // A.1 again, with a stray start carrying a random key mid-expansion
    push_sched(KEY_A1, A1_R1, A1_R10);
    do_start("ign", KEY_A1);
    run_expand("ign", A1_R1, 4,
               {$urandom_range(32'hffff_ffff, 0), $urandom_range(32'hffff_ffff, 0),
                $urandom_range(32'hffff_ffff, 0), $urandom_range(32'hffff_ffff, 1)});
    check_sched("ign");

    // Reset asserted mid-expansion clears everything immediately
    do_start("rst", KEY_A1);
    for (int k = 1; k <= 5; k++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 128'({busy, keys_valid}), 128'(2'b00));
    chk("midrst_state", 128'(dbg_state), 128'(2'd0));
    for (int i = 0; i <= 10; i++) chk($sformatf("midrst_rk%0d", i), rk[i], 128'h0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("postrst_flags_%0d", k), 128'({busy, keys_valid}), 128'(2'b00));
    end

    // Fresh start from IDLE after the reset
    push_sched(KEY_Z, Z_R1, Z_R10);
    do_start("idle2", KEY_Z);
    run_expand("idle2", Z_R1, 0, '0);
    check_sched("idle2");

    chk("sb_empty", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
